// File: rtl/procyon_lsu_pkg.sv
// Shared LSU types and helpers: store-queue entry states, op encodings,
// op-to-lane-mask decode and wrap-safe ROB age compare.
package procyon_lsu_pkg;

  localparam int LSU_OP_WIDTH = 4;

  typedef enum logic [LSU_OP_WIDTH-1:0] {
    LSU_OP_LB  = 4'h0,
    LSU_OP_LH  = 4'h1,
    LSU_OP_LW  = 4'h2,
    LSU_OP_LBU = 4'h4,
    LSU_OP_LHU = 4'h5,
    LSU_OP_SB  = 4'h8,
    LSU_OP_SH  = 4'h9,
    LSU_OP_SW  = 4'ha
  } lsu_op_t;

  typedef enum logic [2:0] {
    SQ_INVALID        = 3'b000,
    SQ_VALID          = 3'b001,
    SQ_MHQ_FILL_WAIT  = 3'b100,
    SQ_NONSPECULATIVE = 3'b101,
    SQ_LAUNCHED       = 3'b110
  } sq_entry_state_t;

  // Unshifted byte mask for a store op; unknown ops cover every lane.
  function automatic logic [63:0] op_lane_mask(input logic [LSU_OP_WIDTH-1:0] op,
                                               input int unsigned lanes);
    int unsigned cnt;
    logic [63:0] m;
    case (op)
      LSU_OP_SB: cnt = 1;
      LSU_OP_SH: cnt = 2;
      LSU_OP_SW: cnt = 4;
      default:   cnt = lanes;
    endcase
    m = '0;
    for (int unsigned i = 0; i < 64; i++) m[i] = (i < cnt);
    return m;
  endfunction

  // Ages are distances from the ROB head, so the compare survives tag wrap.
  function automatic logic rob_older(input logic [31:0] st_tag, input logic [31:0] ld_tag,
                                     input logic [31:0] head, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hffff_ffff : ((32'h1 << w) - 32'h1);
    return ((st_tag - head) & m) < ((ld_tag - head) & m);
  endfunction

endpackage

// File: rtl/procyon_ff.sv
// Enabled register without reset, used for payload that is only meaningful while valid.
module procyon_ff #(
  parameter int OPTN_DATA_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       i_en,
  input  logic [OPTN_DATA_WIDTH-1:0] i_d,
  output logic [OPTN_DATA_WIDTH-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/procyon_lsu_sq_fwd_match.sv
// Store-to-load forwarding compare for one SQ entry: line address, byte overlap and ROB age.
module procyon_lsu_sq_fwd_match import procyon_lsu_pkg::*; #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  localparam int L = OPTN_DATA_WIDTH / 8,
  localparam int O = $clog2(L)
) (
  input  logic                          i_ld_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_ld_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_ld_addr,
  input  logic [L-1:0]                  i_ld_mask,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rob_head_tag,
  input  logic                          i_st_valid,
  input  logic                          i_st_nonspec,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_st_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_st_addr,
  input  logic [L-1:0]                  i_st_mask,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_st_data,
  output logic                          o_fwd_hit,
  output logic                          o_fwd_full,
  output logic [L-1:0]                  o_fwd_mask,
  output logic [OPTN_DATA_WIDTH-1:0]    o_fwd_data
);

  logic         older;
  logic         line_eq;
  logic [L-1:0] overlap;
  logic         unused_lo;

  // A store past retirement is architectural, hence older than any in-flight load.
  assign older   = i_st_nonspec |
                   rob_older(32'(i_st_tag), 32'(i_ld_tag), 32'(i_rob_head_tag), OPTN_ROB_IDX_WIDTH);
  assign line_eq = (i_ld_addr[OPTN_ADDR_WIDTH-1:O] == i_st_addr[OPTN_ADDR_WIDTH-1:O]);
  assign overlap = i_ld_mask & i_st_mask;

  assign o_fwd_hit  = i_ld_en & i_st_valid & older & line_eq & (|overlap);
  assign o_fwd_full = o_fwd_hit & ((i_ld_mask & ~i_st_mask) == '0);
  assign o_fwd_mask = o_fwd_hit ? overlap : '0;

  for (genvar i = 0; i < L; i++) begin : g_lane
    assign o_fwd_data[8*i +: 8] = o_fwd_mask[i] ? i_st_data[8*i +: 8] : 8'h00;
  end

  assign unused_lo = ^{i_ld_addr[O-1:0], i_st_addr[O-1:0]};

endmodule

// File: rtl/procyon_srff.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module procyon_srff #(
  parameter int                         OPTN_DATA_WIDTH  = 1,
  parameter logic [OPTN_DATA_WIDTH-1:0] OPTN_RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_en,
  input  logic [OPTN_DATA_WIDTH-1:0] i_set,
  output logic [OPTN_DATA_WIDTH-1:0] o_q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    o_q <= OPTN_RESET_VALUE;
    else if (i_en) o_q <= i_set;
  end

endmodule

// File: rtl/procyon_lsu_sq_fwd_entry.sv
// One store-queue entry: lifecycle FSM, retry counter and optional load forwarding.
// Forwarding is built only when PROCYON_SQ_FWD_EN is defined; otherwise o_fwd_* are 0.
module procyon_lsu_sq_fwd_entry import procyon_lsu_pkg::*; #(
  parameter int OPTN_DATA_WIDTH      = 32,
  parameter int OPTN_ADDR_WIDTH      = 32,
  parameter int OPTN_ROB_IDX_WIDTH   = 5,
  parameter int OPTN_RETRY_CNT_WIDTH = 3,
  localparam int L = OPTN_DATA_WIDTH / 8,
  localparam int O = $clog2(L)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rob_head_tag,
  input  logic                          i_alloc_en,
  input  logic [LSU_OP_WIDTH-1:0]       i_alloc_op,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_alloc_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_alloc_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_alloc_data,
  input  logic                          i_rob_retire_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rob_retire_tag,
  output logic                          o_rob_retire_ack,
  input  logic                          i_retire_en,
  output logic [LSU_OP_WIDTH-1:0]       o_retire_op,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_retire_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_retire_addr,
  output logic [OPTN_DATA_WIDTH-1:0]    o_retire_data,
  output logic [L-1:0]                  o_retire_mask,
  input  logic                          i_update_en,
  input  logic                          i_update_retry,
  input  logic                          i_update_replay,
  input  logic                          i_update_mhq_retry,
  input  logic                          i_update_mhq_replay,
  input  logic                          i_mhq_fill_en,
  input  logic                          i_ld_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_ld_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_ld_addr,
  input  logic [L-1:0]                  i_ld_mask,
  output logic                          o_fwd_hit,
  output logic                          o_fwd_full,
  output logic [L-1:0]                  o_fwd_mask,
  output logic [OPTN_DATA_WIDTH-1:0]    o_fwd_data,
  output logic                          o_empty,
  output logic                          o_retirable,
  output logic                          o_nonspeculative,
  output logic                          o_retry_limit
);

  localparam int PW = LSU_OP_WIDTH + OPTN_ROB_IDX_WIDTH + OPTN_ADDR_WIDTH + OPTN_DATA_WIDTH + L;

  sq_entry_state_t                 state_q, state_d;
  logic [2:0]                      state_r;
  logic [OPTN_RETRY_CNT_WIDTH-1:0] retry_q, retry_d;
  logic                            alloc_accept;
  logic                            rob_match;
  logic [O-1:0]                    offset;
  logic [L-1:0]                    alloc_mask;
  logic [OPTN_DATA_WIDTH-1:0]      alloc_data;

  assign offset       = i_alloc_addr[O-1:0];
  assign alloc_mask   = L'(op_lane_mask(i_alloc_op, L)) << offset;
  assign alloc_data   = i_alloc_data << {offset, 3'b000};
  assign alloc_accept = i_alloc_en & ~i_flush & (state_q == SQ_INVALID);
  assign rob_match    = i_rob_retire_en & (i_rob_retire_tag == o_retire_tag);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SQ_INVALID:        if (i_alloc_en & ~i_flush) state_d = SQ_VALID;
      SQ_VALID: begin
        if (i_flush)        state_d = SQ_INVALID;
        else if (rob_match) state_d = SQ_NONSPECULATIVE;
      end
      SQ_MHQ_FILL_WAIT:  if (i_mhq_fill_en) state_d = SQ_NONSPECULATIVE;
      SQ_NONSPECULATIVE: if (i_retire_en)   state_d = SQ_LAUNCHED;
      SQ_LAUNCHED: begin
        if (i_flush) state_d = SQ_NONSPECULATIVE;
        else if (i_update_en) begin
          if (i_update_retry & (i_update_replay | i_update_mhq_replay))
            state_d = SQ_NONSPECULATIVE;
          else if (i_update_retry & i_update_mhq_retry)
            state_d = i_mhq_fill_en ? SQ_NONSPECULATIVE : SQ_MHQ_FILL_WAIT;
          else
            state_d = SQ_INVALID;
        end
      end
      default:           state_d = SQ_INVALID;
    endcase
  end

  always_comb begin
    retry_d = retry_q;
    if (alloc_accept) retry_d = '0;
    else if ((state_q == SQ_LAUNCHED) & i_update_en & i_update_retry & ~(&retry_q))
      retry_d = retry_q + 1'b1;
  end

  procyon_srff #(.OPTN_DATA_WIDTH(3), .OPTN_RESET_VALUE(SQ_INVALID)) state_srff (
    .clk, .n_rst, .i_en(1'b1), .i_set(state_d), .o_q(state_r)
  );
  assign state_q = sq_entry_state_t'(state_r);

  procyon_srff #(.OPTN_DATA_WIDTH(OPTN_RETRY_CNT_WIDTH), .OPTN_RESET_VALUE('0)) retry_srff (
    .clk, .n_rst, .i_en(1'b1), .i_set(retry_d), .o_q(retry_q)
  );

  procyon_ff #(.OPTN_DATA_WIDTH(PW)) payload_ff (
    .clk,
    .i_en(alloc_accept),
    .i_d({i_alloc_op, i_alloc_tag, i_alloc_addr, alloc_data, alloc_mask}),
    .o_q({o_retire_op, o_retire_tag, o_retire_addr, o_retire_data, o_retire_mask})
  );

  assign o_rob_retire_ack = (state_q == SQ_VALID) & ~i_flush & rob_match;
  assign o_empty          = (state_q == SQ_INVALID);
  assign o_retirable      = (state_q == SQ_NONSPECULATIVE);
  assign o_nonspeculative = state_q[2];
  assign o_retry_limit    = &retry_q;

`ifdef PROCYON_SQ_FWD_EN
  procyon_lsu_sq_fwd_match #(
    .OPTN_DATA_WIDTH(OPTN_DATA_WIDTH), .OPTN_ADDR_WIDTH(OPTN_ADDR_WIDTH),
    .OPTN_ROB_IDX_WIDTH(OPTN_ROB_IDX_WIDTH)
  ) fwd_match (
    .i_ld_en, .i_ld_tag, .i_ld_addr, .i_ld_mask, .i_rob_head_tag,
    .i_st_valid(state_q != SQ_INVALID), .i_st_nonspec(state_q[2]),
    .i_st_tag(o_retire_tag), .i_st_addr(o_retire_addr), .i_st_mask(o_retire_mask),
    .i_st_data(o_retire_data),
    .o_fwd_hit, .o_fwd_full, .o_fwd_mask, .o_fwd_data
  );
`else
  logic unused_ld;
  assign unused_ld  = ^{i_ld_en, i_ld_tag, i_ld_addr, i_ld_mask, i_rob_head_tag};
  assign o_fwd_hit  = 1'b0;
  assign o_fwd_full = 1'b0;
  assign o_fwd_mask = '0;
  assign o_fwd_data = '0;
`endif

`ifndef SYNTHESIS
  // Allocating over a live entry would corrupt an in-flight store.
  always @(posedge clk) begin
    if (n_rst && i_alloc_en) assert (state_q == SQ_INVALID);
  end
`endif

endmodule
